// File: rtl/mgt_01_fp_round_unit_pkg.sv
// Shared types and constants for the FP rounding unit.
package mgt_01_fp_round_unit_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned FLT_W  = 1 + EXP_W + MANT_W;
  localparam int unsigned GRS_W  = 3;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned FF_W   = 5;
  localparam int unsigned SUM_W  = MANT_W + 2;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
  } float_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;

  localparam logic [FLT_W-1:0] CANON_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/mgt_01_fp_round_unit_if.sv
// Upstream-result / rounded-result bus of the FP rounding unit.
interface mgt_01_fp_round_unit_if;
  import mgt_01_fp_round_unit_pkg::*;

  logic              valid_i;
  float_t            operand_i;
  logic [GRS_W-1:0]  grs_i;
  logic [RM_W-1:0]   rm_i;
  logic              overflow_i;
  logic              underflow_i;
  logic              invalid_i;

  float_t            result_o;
  logic [FF_W-1:0]   fflags_o;
  logic              valid_o;
  fu_state_e         fu_state_o;
  logic              illegal_rm_o;

  modport master (
    output valid_i, operand_i, grs_i, rm_i, overflow_i, underflow_i, invalid_i,
    input  result_o, fflags_o, valid_o, fu_state_o, illegal_rm_o
  );

  modport slave (
    input  valid_i, operand_i, grs_i, rm_i, overflow_i, underflow_i, invalid_i,
    output result_o, fflags_o, valid_o, fu_state_o, illegal_rm_o
  );

endinterface

// File: rtl/mgt_01_fp_round_unit.sv
// Single-precision rounding unit: capture, round-increment, normalize, emit.
// Build option: define FP_ROUND_RMM_EN to support rm=100 (round to nearest,
// ties to max magnitude); otherwise that code is reported as illegal.
module mgt_01_fp_round_unit
  import mgt_01_fp_round_unit_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clk_en_i,
  mgt_01_fp_round_unit_if.slave  fp_if
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROUND     = 2'd1,
    NORMALIZE = 2'd2,
    VALID     = 2'd3
  } state_e;

  state_e             state_q, state_d;

  float_t             op_q;
  logic [GRS_W-1:0]   grs_q;
  logic [RM_W-1:0]    rm_q;
  logic               ovf_in_q, unf_in_q, inv_in_q;

  logic [SUM_W-1:0]   sum_q;

  logic [FLT_W-1:0]   result_q;
  logic [FF_W-1:0]    fflags_q;
  logic               valid_q;
  logic               illegal_q;
  fu_state_e          fu_state_q;

  logic               capture_c;
  logic               rm_legal_c;
  logic               inc_c;

  logic               carry_c;
  logic               hidden_c;
  logic               special_c;
  logic               ovf_rnd_c;
  logic [EXP_W-1:0]   exp_rnd_c;
  logic [MANT_W-1:0]  mant_rnd_c;
  logic [FLT_W-1:0]   res_d;
  logic [FF_W-1:0]    ff_d;

  assign capture_c = (state_q == IDLE) && fp_if.valid_i && clk_en_i;

  // State register; everything holds while the clock enable is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-step pipeline once an operand is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fp_if.valid_i) state_d = ROUND;
      ROUND:     state_d = NORMALIZE;
      NORMALIZE: state_d = VALID;
      VALID:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Operand capture; valid_i is ignored while busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q     <= '0;
      grs_q    <= '0;
      rm_q     <= '0;
      ovf_in_q <= 1'b0;
      unf_in_q <= 1'b0;
      inv_in_q <= 1'b0;
    end else if (capture_c) begin
      op_q     <= fp_if.operand_i;
      grs_q    <= fp_if.grs_i;
      rm_q     <= fp_if.rm_i;
      ovf_in_q <= fp_if.overflow_i;
      unf_in_q <= fp_if.underflow_i;
      inv_in_q <= fp_if.invalid_i;
    end
  end

  // Rounding-mode legality and round-up decision from L, G, R, S and sign.
  always_comb begin
    rm_legal_c = (rm_q < RM_RMM);
    inc_c      = 1'b0;
    case (rm_q)
      RM_RNE:  inc_c = grs_q[2] & (grs_q[1] | grs_q[0] | op_q.mantissa[0]);
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = op_q.sign & (|grs_q);
      RM_RUP:  inc_c = ~op_q.sign & (|grs_q);
`ifdef FP_ROUND_RMM_EN
      RM_RMM: begin
        rm_legal_c = 1'b1;
        inc_c      = grs_q[2];
      end
`endif
      default: inc_c = 1'b0;
    endcase
  end

  // ROUND stage: significand plus increment, keeping the carry-out bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
    end else if (clk_en_i && (state_q == ROUND)) begin
      sum_q <= {1'b0, |op_q.exponent, op_q.mantissa} + SUM_W'(inc_c);
    end
  end

  // NORMALIZE stage: carry/subnormal promotion, overflow, specials, flags.
  always_comb begin
    carry_c    = sum_q[SUM_W-1];
    hidden_c   = |op_q.exponent;
    special_c  = &op_q.exponent;
    exp_rnd_c  = op_q.exponent + EXP_W'(carry_c) + EXP_W'(~hidden_c & sum_q[MANT_W]);
    mant_rnd_c = carry_c ? sum_q[MANT_W:1] : sum_q[MANT_W-1:0];
    ovf_rnd_c  = (&exp_rnd_c) & ~special_c;
    res_d      = {op_q.sign, exp_rnd_c, mant_rnd_c};
    ff_d       = '0;

    if (!rm_legal_c) begin
      res_d = CANON_NAN;
      ff_d  = '0;
    end else if (special_c) begin
      res_d = (|op_q.mantissa) ? CANON_NAN : op_q;
      ff_d  = {inv_in_q, 1'b0, ovf_in_q, unf_in_q, 1'b0};
    end else begin
      if (ovf_rnd_c) begin
        case (rm_q)
          RM_RTZ:  res_d = {op_q.sign, 31'h7F7F_FFFF};
          RM_RDN:  res_d = op_q.sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
          RM_RUP:  res_d = op_q.sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
          default: res_d = {op_q.sign, 31'h7F80_0000};
        endcase
      end
      ff_d = {inv_in_q,
              1'b0,
              ovf_in_q | (ovf_rnd_c & (rm_q != RM_RTZ)),
              unf_in_q,
              (|grs_q) | unf_in_q | ovf_rnd_c};
    end
  end

  // Output registers: results load on entry to VALID and hold until the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q   <= '0;
      fflags_q   <= '0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
      fu_state_q <= FREE;
    end else if (clk_en_i) begin
      valid_q    <= (state_q == NORMALIZE);
      fu_state_q <= (state_d == IDLE) ? FREE : BUSY;
      if (state_q == NORMALIZE) begin
        result_q  <= res_d;
        fflags_q  <= ff_d;
        illegal_q <= ~rm_legal_c;
      end
    end
  end

  assign fp_if.result_o     = float_t'(result_q);
  assign fp_if.fflags_o     = fflags_q;
  assign fp_if.valid_o      = valid_q;
  assign fp_if.illegal_rm_o = illegal_q;
  assign fp_if.fu_state_o   = fu_state_q;

endmodule
